karatsuba_mult_pipe: RTL and testbench

- Parametrised, fully pipelined Karatsuba multiplier; next generation of the fixed-latency karatsuba_mult.
- Adds a valid/ready handshake with backpressure, per-transaction signed/unsigned mode, and a pass-through tag.
- Sits between arithmetic datapath producers and consumers (e.g. modular-reduction units) that may stall.
- One transaction accepted per clock when not stalled.

---
 rtl/karatsuba_pkg.sv | 15 +
 rtl/karatsuba_core_pipe.sv | 83 ++++++++
 rtl/karatsuba_mult_pipe.sv | 126 ++++++++++++
 tb/tb_karatsuba_mult_pipe.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/karatsuba_pkg.sv
// Shared constants and helpers for the pipelined Karatsuba multiplier.
package karatsuba_pkg;

    localparam int unsigned PIPE_LATENCY = 5;

    function automatic int unsigned half_width(input int unsigned w);
        return w / 2;
    endfunction

    // Operands are split into two equal halves, and the halves must be wide enough to be useful.
    function automatic bit width_ok(input int unsigned w);
        return ((w % 2) == 0) && (w >= 8);
    endfunction

endpackage

// File: rtl/karatsuba_core_pipe.sv
// Unsigned Karatsuba core: split/pre-add, three half-width products, middle-term recovery.
module karatsuba_core_pipe
    import karatsuba_pkg::*;
#(
    parameter int unsigned W = 64,
    localparam int unsigned H = half_width(W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    input  logic [W-1:0]      a,
    input  logic [W-1:0]      b,
    output logic              out_valid,
    output logic [2*H-1:0]    z2,
    output logic [2*H-1:0]    z0,
    output logic [2*H+1:0]    z1
);

    localparam int unsigned SW  = H + 1;
    localparam int unsigned ZW  = 2 * H;
    localparam int unsigned ZMW = 2 * H + 2;

    logic           s2_valid;
    logic [H-1:0]   s2_a1, s2_a0, s2_b1, s2_b0;
    logic [SW-1:0]  s2_sa, s2_sb;

    logic           s3_valid;
    logic [ZW-1:0]  s3_z2, s3_z0;
    logic [ZMW-1:0] s3_zm;

    // Stage 2: split into halves and form the (H+1)-bit half sums.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_a1    <= '0;
            s2_a0    <= '0;
            s2_b1    <= '0;
            s2_b0    <= '0;
            s2_sa    <= '0;
            s2_sb    <= '0;
        end else if (en) begin
            s2_valid <= in_valid;
            s2_a1    <= a[W-1:H];
            s2_a0    <= a[H-1:0];
            s2_b1    <= b[W-1:H];
            s2_b0    <= b[H-1:0];
            s2_sa    <= SW'(a[W-1:H]) + SW'(a[H-1:0]);
            s2_sb    <= SW'(b[W-1:H]) + SW'(b[H-1:0]);
        end
    end

    // Stage 3: the three partial products.
    always_ff @(posedge clk) begin
        if (rst) begin
            s3_valid <= 1'b0;
            s3_z2    <= '0;
            s3_z0    <= '0;
            s3_zm    <= '0;
        end else if (en) begin
            s3_valid <= s2_valid;
            s3_z2    <= ZW'(s2_a1) * ZW'(s2_b1);
            s3_z0    <= ZW'(s2_a0) * ZW'(s2_b0);
            s3_zm    <= ZMW'(s2_sa) * ZMW'(s2_sb);
        end
    end

    // Stage 4: z1 = zm - z2 - z0 is always non-negative, so no wrap handling is needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            z2        <= '0;
            z0        <= '0;
            z1        <= '0;
        end else if (en) begin
            out_valid <= s3_valid;
            z2        <= s3_z2;
            z0        <= s3_z0;
            z1        <= s3_zm - ZMW'(s3_z2) - ZMW'(s3_z0);
        end
    end

endmodule

// File: rtl/karatsuba_mult_pipe.sv
// Pipelined signed/unsigned Karatsuba multiplier with valid/ready backpressure and a pass-through tag.
module karatsuba_mult_pipe
    import karatsuba_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 64,
    parameter int unsigned TAG_WIDTH = 4,
    parameter int unsigned LATENCY   = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_WIDTH-1:0]     a,
    input  logic [IN_WIDTH-1:0]     b,
    input  logic                    sgn,
    input  logic [TAG_WIDTH-1:0]    in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*IN_WIDTH-1:0]   o,
    output logic [TAG_WIDTH-1:0]    out_tag
);

    localparam int unsigned H   = half_width(IN_WIDTH);
    localparam int unsigned ZW  = 2 * H;
    localparam int unsigned ZMW = 2 * H + 2;
    localparam int unsigned PW  = 2 * IN_WIDTH;

    if (!width_ok(IN_WIDTH)) begin : g_bad_width
        $error("karatsuba_mult_pipe: IN_WIDTH must be even and at least 8");
    end
    if (LATENCY != PIPE_LATENCY) begin : g_bad_latency
        $error("karatsuba_mult_pipe: LATENCY must equal the fixed pipeline depth");
    end

    logic                   adv;
    logic                   s1_valid;
    logic [IN_WIDTH-1:0]    s1_a, s1_b;
    logic                   s1_sgn;
    logic [TAG_WIDTH-1:0]   s1_tag;

    logic [IN_WIDTH-1:0]    a_mag, b_mag;
    logic                   s1_neg;

    logic [2:0]                 neg_q;
    logic [2:0][TAG_WIDTH-1:0]  tag_q;

    logic               core_valid;
    logic [ZW-1:0]      core_z2, core_z0;
    logic [ZMW-1:0]     core_z1;
    logic [PW-1:0]      p_sum;

    // Whole pipeline moves as one; a full output register that is not being drained freezes it.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Stage 1: capture the raw operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_sgn   <= 1'b0;
            s1_tag   <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_a     <= a;
            s1_b     <= b;
            s1_sgn   <= sgn;
            s1_tag   <= in_tag;
        end
    end

    // Magnitudes as IN_WIDTH unsigned bits; the most negative value maps onto 2^(IN_WIDTH-1).
    always_comb begin
        a_mag  = s1_a;
        b_mag  = s1_b;
        s1_neg = 1'b0;
        if (s1_sgn) begin
            if (s1_a[IN_WIDTH-1]) a_mag = IN_WIDTH'(~s1_a + 1'b1);
            if (s1_b[IN_WIDTH-1]) b_mag = IN_WIDTH'(~s1_b + 1'b1);
            s1_neg = s1_a[IN_WIDTH-1] ^ s1_b[IN_WIDTH-1];
        end
    end

    karatsuba_core_pipe #(
        .W          (IN_WIDTH)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .en         (adv),
        .in_valid   (s1_valid),
        .a          (a_mag),
        .b          (b_mag),
        .out_valid  (core_valid),
        .z2         (core_z2),
        .z0         (core_z0),
        .z1         (core_z1)
    );

    // Sign and tag ride alongside core stages 2..4.
    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q <= '0;
            tag_q <= '0;
        end else if (adv) begin
            neg_q <= {neg_q[1:0], s1_neg};
            tag_q <= {tag_q[1:0], s1_tag};
        end
    end

    assign p_sum = {core_z2, core_z0} + (PW'(core_z1) << H);

    // Stage 5: recombine and restore the sign.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            o         <= '0;
            out_tag   <= '0;
        end else if (adv) begin
            out_valid <= core_valid;
            o         <= neg_q[2] ? PW'(~p_sum + 1'b1) : p_sum;
            out_tag   <= tag_q[2];
        end
    end

endmodule

// File: tb/tb_karatsuba_mult_pipe.sv
// Scoreboard bench for karatsuba_mult_pipe at IN_WIDTH = 32, TAG_WIDTH = 4.
module tb_karatsuba_mult_pipe;

    localparam int unsigned W   = 32;
    localparam int unsigned TW  = 4;
    localparam int unsigned LAT = 5;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic            sgn;
    logic [TW-1:0]   in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  o;
    logic [TW-1:0]   out_tag;

    karatsuba_mult_pipe #(
        .IN_WIDTH   (W),
        .TAG_WIDTH  (TW),
        .LATENCY    (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .sgn        (sgn),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .o          (o),
        .out_tag    (out_tag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [63:0]   prod;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t           sb_q[$];
    int             checks = 0;
    int             errors = 0;
    logic           prev_stall = 1'b0;
    logic [63:0]    prev_o = '0;
    logic [TW-1:0]  prev_tag = '0;

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic [63:0] xe;
        logic [63:0] ye;
        xe = s ? {{32{x[31]}}, x} : {32'b0, x};
        ye = s ? {{32{y[31]}}, y} : {32'b0, y};
        return xe * ye;
    endfunction

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // One clock: drive at the falling edge, then observe the state left by the previous rising edge.
    task automatic step(input logic r, input logic v, input logic [31:0] x, input logic [31:0] y,
                        input logic s, input logic [3:0] t, input logic ordy, output logic acc);
        exp_t e;
        @(negedge clk);
        rst       = r;
        in_valid  = v;
        a         = x;
        b         = y;
        sgn       = s;
        in_tag    = t;
        out_ready = ordy;
        #1;
        acc = 1'b0;
        if (r) begin
            prev_stall = 1'b0;
            sb_q.delete();
            return;
        end
        check_eq("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
        if (prev_stall) begin
            check_eq("hold_valid", 64'(out_valid), 64'(1));
            check_eq("hold_o", o, prev_o);
            check_eq("hold_tag", 64'(out_tag), 64'(prev_tag));
        end
        if (out_valid === 1'b1 && ordy) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_valid", 64'(out_valid), 64'(0));
            end else begin
                e = sb_q.pop_front();
                check_eq("sb_o", o, e.prod);
                check_eq("sb_tag", 64'(out_tag), 64'(e.tag));
            end
        end
        prev_stall = (out_valid === 1'b1) && !ordy;
        prev_o     = o;
        prev_tag   = out_tag;
        if (v && in_ready === 1'b1) begin
            e.prod = ref_mul(x, y, s);
            e.tag  = t;
            sb_q.push_back(e);
            acc = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, acc);
    endtask

    // Single op into an empty pipe: result must show up exactly LAT cycles later, for one cycle.
    task automatic one_op(input string name, input logic [31:0] x, input logic [31:0] y,
                          input logic s, input logic [3:0] t, input logic [63:0] exp_o);
        logic acc;
        step(1'b0, 1'b1, x, y, s, t, 1'b1, acc);
        check_eq({name, "_acc"}, 64'(acc), 64'(1));
        for (int k = 1; k <= LAT + 1; k++) begin
            step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, acc);
            check_eq({name, "_valid"}, 64'(out_valid), 64'(k == LAT));
            if (k == LAT) begin
                check_eq({name, "_o"}, o, exp_o);
                check_eq({name, "_tag"}, 64'(out_tag), 64'(t));
            end
        end
    endtask

    initial begin
        logic        acc;
        logic [31:0] x;
        logic [31:0] y;
        int          sent;
        int          cyc;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sgn = 1'b0; in_tag = '0; out_ready = 1'b1;
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b1, acc);
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b1, acc);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, acc);
        check_eq("rst_valid", 64'(out_valid), 64'(0));
        check_eq("rst_o", o, 64'(0));
        check_eq("rst_tag", 64'(out_tag), 64'(0));
        check_eq("rst_ready", 64'(in_ready), 64'(1));

        one_op("umax",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'd3, 64'hFFFF_FFFE_0000_0001);
        one_op("smin2",  32'h8000_0000, 32'h8000_0000, 1'b1, 4'd5, 64'h4000_0000_0000_0000);
        one_op("sneg1",  32'hFFFF_FFFF, 32'h0000_0007, 1'b1, 4'd6, 64'hFFFF_FFFF_FFFF_FFF9);
        one_op("carry1", 32'h0000_FFFF, 32'hFFFF_0000, 1'b0, 4'd9, 64'h0000_FFFE_0001_0000);
        one_op("carry2", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4'd10, 64'h0000_0000_FFFF_FFFF);

        // Back-to-back stream with the consumer always ready.
        for (int i = 0; i < 1000; i++) begin
            x = $urandom;
            y = $urandom;
            if (i % 97 == 0) x = 32'h8000_0000;
            if (i % 89 == 0) y = 32'hFFFF_FFFF;
            step(1'b0, 1'b1, x, y, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b1, acc);
            if (i >= int'(LAT)) check_eq("tput_valid", 64'(out_valid), 64'(1));
        end
        idle(LAT + 2);
        check_eq("tput_drain", 64'(sb_q.size()), 64'(0));

        // Random backpressure and input gaps.
        sent = 0;
        cyc  = 0;
        while (sent < 200 && cyc < 4000) begin
            step(1'b0, 1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), acc);
            if (acc) sent++;
            cyc++;
        end
        check_eq("bp_sent", 64'(sent), 64'(200));
        cyc = 0;
        while (sb_q.size() != 0 && cyc < 50) begin
            idle(1);
            cyc++;
        end
        check_eq("bp_drain", 64'(sb_q.size()), 64'(0));

        // Reset with four operations in flight; none of them may come out.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, $urandom, $urandom, 1'b0, 4'(i + 1), 1'b1, acc);
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b1, acc);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, acc);
        check_eq("mrst_valid", 64'(out_valid), 64'(0));
        check_eq("mrst_o", o, 64'(0));
        one_op("post_rst", 32'h0001_2345, 32'hFFFF_FFFE, 1'b1, 4'd12, 64'hFFFF_FFFF_FFFD_B976);
        idle(LAT + 4);

        check_eq("final_empty", 64'(sb_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
